// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and encodings for the AHB-Lite to APB bridge.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to single-slave APB master; one SETUP+ACCESS per accepted word transfer.
// Wait states held until PREADY; PSLVERR and illegal transfers give a two-cycle ERROR.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int AHB_ADDR_WIDTH = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  state_t                    state, next_state;
  logic                      accept, legal, can_accept;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [2:0]                size_q;

  assign accept     = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign legal      = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00);
  assign can_accept = (state == IDLE) || (state == ERR2);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, ERR2: begin
        if (!accept)     next_state = IDLE;
        else if (!legal) next_state = ERR1;
        else if (HWRITE) next_state = WDATA;
        else             next_state = SETUP;
      end
      WDATA:  next_state = SETUP;
      SETUP:  next_state = ACCESS;
      ACCESS: if (PREADY) next_state = PSLVERR ? ERR1 : IDLE;
      ERR1:   next_state = ERR2;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = (state == IDLE) || (state == ERR2);
    HRESP     = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    PSEL      = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
  end

  // Address phase is latched even for illegal transfers; it simply never reaches APB.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      PWDATA  <= 32'h0;
      HRDATA  <= 32'h0;
    end else begin
      if (can_accept && accept) begin
        addr_q  <= HADDR[APB_ADDR_WIDTH-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      if (state == WDATA) PWDATA <= HWDATA;
      if ((state == ACCESS) && PREADY && !PSLVERR && !write_q) HRDATA <= PRDATA;
    end
  end

  assign PADDR  = addr_q;
  assign PWRITE = write_q;

  logic unused_bits;
  assign unused_bits = ^{HADDR[AHB_ADDR_WIDTH-1:APB_ADDR_WIDTH], size_q};

endmodule
